// File: rtl/scene_pkg.sv
// Shared types and helpers for the scene timing engine: pattern ids, the scene
// sequencer states and the line/frame total helper.
package scene_pkg;

  typedef enum logic [1:0] {
    PAT_BARS     = 2'd0,
    PAT_CHECKER  = 2'd1,
    PAT_XOR      = 2'd2,
    PAT_GRADIENT = 2'd3
  } pattern_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } scene_state_e;

  // Total length of a line or frame from its visible/porch/sync segments.
  function automatic int unsigned line_total(input int unsigned vis,
                                             input int unsigned front,
                                             input int unsigned sync,
                                             input int unsigned back);
    return vis + front + sync + back;
  endfunction

endpackage

// File: rtl/scene_video_timing.sv
// VGA raster timing: h/v counters, registered display_on/sync and a frame_tick
// that is high while the counters sit on the last pixel of the frame.
module scene_video_timing
  import scene_pkg::*;
#(
  parameter int unsigned H_VISIBLE        = 640,
  parameter int unsigned H_FRONT          = 16,
  parameter int unsigned H_SYNC           = 96,
  parameter int unsigned H_BACK           = 48,
  parameter int unsigned V_VISIBLE        = 480,
  parameter int unsigned V_FRONT          = 10,
  parameter int unsigned V_SYNC           = 2,
  parameter int unsigned V_BACK           = 33,
  parameter int unsigned SYNC_ACTIVE_HIGH = 0
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       visible_c,
  output logic       display_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick
);

  localparam int unsigned H_TOTAL  = line_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL  = line_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam logic        SYNC_ON  = (SYNC_ACTIVE_HIGH != 0);

  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic       display_on_q, display_on_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       frame_tick_q, frame_tick_d;
  logic       h_wrap, v_wrap, hs_act, vs_act;

  always_comb begin
    h_wrap    = (hpos_q == 10'(H_TOTAL - 1));
    v_wrap    = (vpos_q == 10'(V_TOTAL - 1));
    hpos_d    = h_wrap ? 10'd0 : hpos_q + 10'd1;
    vpos_d    = vpos_q;
    if (h_wrap) begin
      vpos_d = v_wrap ? 10'd0 : vpos_q + 10'd1;
    end
    visible_c    = (hpos_q < 10'(H_VISIBLE)) && (vpos_q < 10'(V_VISIBLE));
    hs_act       = (hpos_q >= 10'(HS_START)) && (hpos_q < 10'(HS_END));
    vs_act       = (vpos_q >= 10'(VS_START)) && (vpos_q < 10'(VS_END));
    display_on_d = visible_c;
    hsync_d      = hs_act ? SYNC_ON : ~SYNC_ON;
    vsync_d      = vs_act ? SYNC_ON : ~SYNC_ON;
    // Registered so it is high exactly while the counters show the frame's last pixel.
    frame_tick_d = (hpos_d == 10'(H_TOTAL - 1)) && (vpos_d == 10'(V_TOTAL - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hpos_q       <= 10'd0;
      vpos_q       <= 10'd0;
      display_on_q <= 1'b0;
      hsync_q      <= ~SYNC_ON;
      vsync_q      <= ~SYNC_ON;
      frame_tick_q <= 1'b0;
    end else begin
      hpos_q       <= hpos_d;
      vpos_q       <= vpos_d;
      display_on_q <= display_on_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign hpos       = hpos_q;
  assign vpos       = vpos_q;
  assign display_on = display_on_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: rtl/scene_timing_engine.sv
// Demoscene video core: raster timing, frame counter, scene sequencer with a
// valid/ready override port, and a registered procedural pattern renderer.
module scene_timing_engine
  import scene_pkg::*;
#(
  parameter int unsigned H_VISIBLE        = 640,
  parameter int unsigned H_FRONT          = 16,
  parameter int unsigned H_SYNC           = 96,
  parameter int unsigned H_BACK           = 48,
  parameter int unsigned V_VISIBLE        = 480,
  parameter int unsigned V_FRONT          = 10,
  parameter int unsigned V_SYNC           = 2,
  parameter int unsigned V_BACK           = 33,
  parameter int unsigned SYNC_ACTIVE_HIGH = 0,
  parameter int unsigned COLOR_BITS       = 2,
  parameter int unsigned NUM_SCENES       = 4,
  parameter int unsigned FRAMES_PER_SCENE = 120
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  auto_en,
  input  logic                  req_valid,
  input  logic [3:0]            req_scene,
  output logic                  req_ready,
  output logic                  req_err,
  output logic [9:0]            hpos,
  output logic [9:0]            vpos,
  output logic                  display_on,
  output logic                  hsync,
  output logic                  vsync,
  output logic [COLOR_BITS-1:0] vga_r,
  output logic [COLOR_BITS-1:0] vga_g,
  output logic [COLOR_BITS-1:0] vga_b,
  output logic [15:0]           frame_count,
  output logic [3:0]            scene,
  output logic                  frame_tick
);

  localparam int unsigned CB      = COLOR_BITS;
  localparam int unsigned RGB_W   = 3 * CB;
  localparam int unsigned BAR_W   = H_VISIBLE / 8;
  localparam int unsigned COL_W   = $clog2(BAR_W + 1);
  localparam int unsigned TIMER_W = $clog2(FRAMES_PER_SCENE + 1);
  localparam int unsigned H_TOTAL = line_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);

  logic visible_c;

  scene_video_timing #(
    .H_VISIBLE       (H_VISIBLE),
    .H_FRONT         (H_FRONT),
    .H_SYNC          (H_SYNC),
    .H_BACK          (H_BACK),
    .V_VISIBLE       (V_VISIBLE),
    .V_FRONT         (V_FRONT),
    .V_SYNC          (V_SYNC),
    .V_BACK          (V_BACK),
    .SYNC_ACTIVE_HIGH(SYNC_ACTIVE_HIGH)
  ) u_timing (
    .clk       (clk),
    .reset     (reset),
    .hpos      (hpos),
    .vpos      (vpos),
    .visible_c (visible_c),
    .display_on(display_on),
    .hsync     (hsync),
    .vsync     (vsync),
    .frame_tick(frame_tick)
  );

  scene_state_e       state_q, state_d;
  logic [3:0]         scene_q, scene_d;
  logic [3:0]         pend_q, pend_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               req_ready_q, req_ready_d;
  logic               req_err_q, req_err_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [2:0]         bar_q, bar_d;
  logic [CB-1:0]      r_q, r_d, g_q, g_d, b_q, b_d;
  logic [CB-1:0]      pat_r, pat_g, pat_b;
  logic [RGB_W-1:0]   xor_v;
  logic [9:0]         f10;
  logic               chk_c;

  // Scene sequencer: pending requests win over auto-advance at the frame end;
  // a request accepted on the frame-end cycle waits for the following one.
  always_comb begin
    state_d       = state_q;
    scene_d       = scene_q;
    timer_d       = timer_q;
    pend_d        = pend_q;
    req_err_d     = 1'b0;
    frame_count_d = frame_tick ? frame_count_q + 16'd1 : frame_count_q;
    if (frame_tick) begin
      if (state_q == ST_PENDING) begin
        scene_d = pend_q;
        timer_d = '0;
        state_d = ST_IDLE;
      end else if (auto_en) begin
        if (timer_q == TIMER_W'(FRAMES_PER_SCENE - 1)) begin
          scene_d = (scene_q == 4'(NUM_SCENES - 1)) ? 4'd0 : scene_q + 4'd1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
    end
    if (req_valid && req_ready_q) begin
      if ({1'b0, req_scene} >= 5'(NUM_SCENES)) begin
        req_err_d = 1'b1;
      end else begin
        pend_d  = req_scene;
        state_d = ST_PENDING;
      end
    end
    req_ready_d = (state_d == ST_IDLE);
  end

  // Bar tracker follows hpos so that bar_q is the bar of the current pixel.
  always_comb begin
    col_d = col_q;
    bar_d = bar_q;
    if (hpos == 10'(H_TOTAL - 1)) begin
      col_d = '0;
      bar_d = 3'd0;
    end else if (col_q == COL_W'(BAR_W - 1)) begin
      col_d = '0;
      bar_d = bar_q + 3'd1;
    end else begin
      col_d = col_q + COL_W'(1);
    end
  end

  always_comb begin
    f10   = frame_count_q[9:0];
    chk_c = 1'((hpos + f10) >> 4) ^ vpos[4];
    xor_v = RGB_W'((hpos ^ vpos) + f10);
    pat_r = '0;
    pat_g = '0;
    pat_b = '0;
    case (pattern_e'(scene_q[1:0]))
      PAT_BARS: begin
        pat_r = {CB{bar_q[0]}};
        pat_g = {CB{bar_q[1]}};
        pat_b = {CB{bar_q[2]}};
      end
      PAT_CHECKER: begin
        pat_r = {CB{chk_c}};
        pat_g = {CB{chk_c}};
        pat_b = {CB{chk_c}};
      end
      PAT_XOR: begin
        pat_r = xor_v[CB-1:0];
        pat_g = xor_v[2*CB-1:CB];
        pat_b = xor_v[3*CB-1:2*CB];
      end
      PAT_GRADIENT: begin
        pat_r = hpos[8 -: CB];
        pat_g = vpos[8 -: CB];
        pat_b = frame_count_q[7 -: CB];
      end
    endcase
    r_d = visible_c ? pat_r : '0;
    g_d = visible_c ? pat_g : '0;
    b_d = visible_c ? pat_b : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      scene_q       <= 4'd0;
      pend_q        <= 4'd0;
      timer_q       <= '0;
      req_ready_q   <= 1'b1;
      req_err_q     <= 1'b0;
      frame_count_q <= 16'd0;
      col_q         <= '0;
      bar_q         <= 3'd0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
    end else begin
      state_q       <= state_d;
      scene_q       <= scene_d;
      pend_q        <= pend_d;
      timer_q       <= timer_d;
      req_ready_q   <= req_ready_d;
      req_err_q     <= req_err_d;
      frame_count_q <= frame_count_d;
      col_q         <= col_d;
      bar_q         <= bar_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign req_err     = req_err_q;
  assign frame_count = frame_count_q;
  assign scene       = scene_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;

endmodule

// File: tb/tb_scene_timing_engine.sv
// Directed bench for scene_timing_engine on a tiny raster (12x7 totals) with a
// cycle model feeding a scoreboard, plus directed sequencer/handshake checks.
module tb_scene_timing_engine;

  localparam int HV = 8, HF = 1, HS = 2, HB = 1;
  localparam int VV = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int CB = 2, NS = 3, FPS = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          auto_en = 1'b0;
  logic          req_valid = 1'b0;
  logic [3:0]    req_scene = 4'd0;
  logic          req_ready, req_err, display_on, hsync, vsync, frame_tick;
  logic [9:0]    hpos, vpos;
  logic [CB-1:0] vga_r, vga_g, vga_b;
  logic [15:0]   frame_count;
  logic [3:0]    scene;

  scene_timing_engine #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE_HIGH(0), .COLOR_BITS(CB), .NUM_SCENES(NS), .FRAMES_PER_SCENE(FPS)
  ) dut (
    .clk(clk), .reset(reset), .auto_en(auto_en), .req_valid(req_valid),
    .req_scene(req_scene), .req_ready(req_ready), .req_err(req_err),
    .hpos(hpos), .vpos(vpos), .display_on(display_on), .hsync(hsync),
    .vsync(vsync), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_count(frame_count), .scene(scene), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        disp;
    logic        hs;
    logic        vs;
    logic [1:0]  r;
    logic [1:0]  g;
    logic [1:0]  b;
    logic [15:0] fc;
    logic [3:0]  sc;
    logic        tick;
    logic        rdy;
    logic        err;
  } obs_t;

  obs_t       sb[$];
  logic [3:0] scene_log[$];
  logic [3:0] last_sc = 4'd0;
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         ticks = 0;
  int         m_h, m_v, m_fc, m_sc, m_tm, m_pd;
  bit         m_pv;

  function automatic void pattern(input int sc, input int h, input int v, input int f,
                                  output logic [1:0] r, output logic [1:0] g,
                                  output logic [1:0] b);
    int c, x;
    case (sc % 4)
      0: begin
        c = h / (HV / 8);
        r = 2'((c & 1) != 0 ? 3 : 0);
        g = 2'((c & 2) != 0 ? 3 : 0);
        b = 2'((c & 4) != 0 ? 3 : 0);
      end
      1: begin
        c = (((h + f) % 1024) / 16) % 2 ^ ((v / 16) % 2);
        r = 2'(c * 3); g = 2'(c * 3); b = 2'(c * 3);
      end
      2: begin
        x = ((h ^ v) + f) % 64;
        r = 2'(x % 4); g = 2'((x / 4) % 4); b = 2'(x / 16);
      end
      default: begin
        r = 2'((h / 128) % 4); g = 2'((v / 128) % 4); b = 2'((f % 256) / 64);
      end
    endcase
  endfunction

  // Advance the model by one clock with the inputs currently driven; push the
  // outputs expected after that edge.
  task automatic model_cycle();
    obs_t o;
    bit   tick_now, vis, rdy_now;
    o = '0;
    if (reset) begin
      m_h = 0; m_v = 0; m_fc = 0; m_sc = 0; m_tm = 0; m_pd = 0; m_pv = 0;
      o.hs = 1'b1; o.vs = 1'b1; o.rdy = 1'b1;
    end else begin
      tick_now = (m_h == HT - 1) && (m_v == VT - 1);
      vis      = (m_h < HV) && (m_v < VV);
      o.disp   = vis;
      o.hs     = !((m_h >= HV + HF) && (m_h < HV + HF + HS));
      o.vs     = !((m_v >= VV + VF) && (m_v < VV + VF + VS));
      pattern(m_sc, m_h, m_v, m_fc % 1024, o.r, o.g, o.b);
      if (!vis) begin
        o.r = 2'd0; o.g = 2'd0; o.b = 2'd0;
      end
      rdy_now = !m_pv;
      if (tick_now) begin
        if (m_pv) begin
          m_sc = m_pd; m_tm = 0; m_pv = 0;
        end else if (auto_en) begin
          if (m_tm == FPS - 1) begin
            m_sc = (m_sc + 1) % NS; m_tm = 0;
          end else begin
            m_tm = m_tm + 1;
          end
        end
      end
      if (req_valid && rdy_now) begin
        if (int'(req_scene) >= NS) o.err = 1'b1;
        else begin
          m_pv = 1; m_pd = int'(req_scene);
        end
      end
      if (tick_now) m_fc = (m_fc + 1) % 65536;
      m_h = m_h + 1;
      if (m_h == HT) begin
        m_h = 0;
        m_v = (m_v + 1) % VT;
      end
      o.rdy = !m_pv;
    end
    o.h    = 10'(m_h);
    o.v    = 10'(m_v);
    o.fc   = 16'(m_fc);
    o.sc   = 4'(m_sc);
    o.tick = (m_h == HT - 1) && (m_v == VT - 1);
    sb.push_back(o);
  endtask

  task automatic step();
    obs_t exp_o, got;
    model_cycle();
    @(posedge clk);
    #1;
    cyc++;
    exp_o = sb.pop_front();
    got = '{h: hpos, v: vpos, disp: display_on, hs: hsync, vs: vsync,
            r: vga_r, g: vga_g, b: vga_b, fc: frame_count, sc: scene,
            tick: frame_tick, rdy: req_ready, err: req_err};
    n_checks++;
    assert (got === exp_o)
    else begin
      n_errors++;
      $error("FAIL cycle%0d observed %h expected %h", cyc, got, exp_o);
    end
    if (frame_tick === 1'b1) ticks++;
    if (scene !== last_sc) scene_log.push_back(scene);
    last_sc = scene;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    // Reset state
    run(2);
    chk("rst_hpos", 16'(hpos), 16'd0);
    chk("rst_scene", 16'(scene), 16'd0);
    chk("rst_ready", 16'(req_ready), 16'd1);
    chk("rst_sync", 16'({hsync, vsync}), 16'd3);
    chk("rst_rgb", 16'({vga_r, vga_g, vga_b}), 16'd0);

    // Auto-advance: 0 -> 1 -> 2 -> 0 on every second frame end
    reset = 1'b0;
    auto_en = 1'b1;
    ticks = 0;
    run(FT * 7);
    chk("auto_ticks", 16'(ticks), 16'd7);
    chk("auto_nchg", 16'(scene_log.size()), 16'd3);
    chk("auto_seq0", 16'(scene_log[0]), 16'd1);
    chk("auto_seq1", 16'(scene_log[1]), 16'd2);
    chk("auto_seq2", 16'(scene_log[2]), 16'd0);

    // Hold with auto advance off
    auto_en = 1'b0;
    scene_log.delete();
    run(FT * 3);
    chk("hold_nchg", 16'(scene_log.size()), 16'd0);

    // Mid-frame request for scene 2, then timer restarts
    run(20);
    req_valid = 1'b1; req_scene = 4'd2;
    step();
    req_valid = 1'b0;
    chk("req_ready_low", 16'(req_ready), 16'd0);
    auto_en = 1'b1;
    scene_log.delete();
    run(FT);
    chk("req_applied", 16'(scene), 16'd2);
    chk("req_ready_back", 16'(req_ready), 16'd1);
    scene_log.delete();
    run(FT);
    chk("req_timer_hold", 16'(scene_log.size()), 16'd0);
    run(FT);
    chk("req_then_auto", 16'(scene), 16'd0);

    // Out-of-range request
    req_valid = 1'b1; req_scene = 4'd5;
    step();
    req_valid = 1'b0;
    chk("err_pulse", 16'(req_err), 16'd1);
    chk("err_ready", 16'(req_ready), 16'd1);
    step();
    chk("err_clear", 16'(req_err), 16'd0);
    chk("err_scene", 16'(scene), 16'd0);

    // Request on the frame-end cycle lands one frame later
    auto_en = 1'b0;
    guard = 0;
    while (!(m_h == HT - 1 && m_v == VT - 1) && guard < 2 * FT) begin
      step();
      guard++;
    end
    chk("tick_found", 16'(frame_tick), 16'd1);
    req_valid = 1'b1; req_scene = 4'd1;
    step();
    req_valid = 1'b0;
    chk("tick_req_not_now", 16'(scene), 16'd0);
    run(FT - 1);
    chk("tick_req_still", 16'(scene), 16'd0);
    step();
    chk("tick_req_applied", 16'(scene), 16'd1);

    // Reset mid-line with a request pending
    req_valid = 1'b1; req_scene = 4'd2;
    step();
    req_valid = 1'b0;
    guard = 0;
    while (m_h != 5 && guard < HT) begin
      step();
      guard++;
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_hpos", 16'(hpos), 16'd0);
    chk("mid_rst_scene", 16'(scene), 16'd0);
    chk("mid_rst_ready", 16'(req_ready), 16'd1);
    run(FT * 2);
    chk("mid_rst_discard", 16'(scene), 16'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
